pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Owns and sequences the 64-bit program counter for the IF stage of the pipelined ARMv8 core.
//   Issues fetch requests to instruction memory with a req/ack handshake.
//   Advances the PC by one instruction per accepted fetch.
//   Holds the PC on hazard stalls, applies branch redirects from EX/MEM, and drives IF/ID flush bubbles.
// PARAMETERS
//   RESET_PC      64'h0  PC value loaded on reset
//   INSTR_BYTES   4      PC increment per accepted fetch
//   FLUSH_CYCLES  2      IF/ID bubbles inserted after a redirect (1..7)
// PORTS
//   clk            in   1   rising-edge clock
//   Reset          in   1   asynchronous, active-low reset (0 = reset)
//   stall_i        in   1   hazard unit: hold PC and fetch
//   br_taken_i     in   1   redirect strobe from EX/MEM (single-cycle)
//   br_target_i    in   64  redirect address, sampled when br_taken_i=1
//   imem_req_o     out  1   fetch request; address = pc_q
//   imem_ack_i     in   1   memory accepted request this cycle
//   pc_q           out  64  current fetch PC
//   instr_valid_o  out  1   fetched word valid into IF/ID this cycle
//   flush_ifid_o   out  1   kill IF/ID contents
//   align_fault_o  out  1   sticky: redirect target not 4-byte aligned
//   fetch_cnt_o    out  32  accepted fetches, saturating
// BEHAVIOUR
//   - Reset (async, Reset=0):
//     - pc_q=RESET_PC; state=BOOT; all 1-bit outputs 0; fetch_cnt_o=0.
//     - Release takes effect at the next clk edge.
//   - FSM states: BOOT, FETCH, STALL, FLUSH.
//     - BOOT -> FETCH after exactly 1 cycle; imem_req_o=0 in BOOT.
//     - FETCH: imem_req_o=1. Mutually exclusive transitions:
//       - redirect -> FLUSH
//       - else stall_i -> STALL
//       - else stay in FETCH
//     - STALL: imem_req_o=0; pc_q held.
//       - stall_i=0 -> FETCH
//       - redirect -> FLUSH (redirect wins over stall)
//     - FLUSH: imem_req_o=1 at the new PC.
//       - flush_ifid_o=1 for exactly FLUSH_CYCLES cycles, counted from the cycle after the redirect.
//       - Then -> FETCH, or STALL if stall_i=1.
//   - Priority per cycle: Reset > br_taken_i > stall_i > imem_ack_i.
//   - Handshake:
//     - pc_q stays stable while imem_req_o=1 and imem_ack_i=0.
//     - On an accepted fetch (imem_req_o & imem_ack_i & ~stall_i & ~br_taken_i):
//       - pc_q <= pc_q + INSTR_BYTES (mod 2^64; wraps silently).
//       - fetch_cnt_o increments and saturates at 32'hFFFF_FFFF.
//       - instr_valid_o=1 in the same cycle, unless in FLUSH.
//   - Redirect:
//     - pc_q <= {br_target_i[63:2],2'b00} next cycle.
//     - An outstanding request is abandoned; an ack in the redirect cycle is ignored (no increment, no valid).
//     - If br_target_i[1:0]!=0, align_fault_o is set and stays set until reset.
//     - A redirect during FLUSH restarts the flush counter.
//   - stall_i and imem_ack_i in the same cycle: the ack is discarded; the same PC is re-requested after the stall.
//   - instr_valid_o and flush_ifid_o are never both 1.
// STRUCTURE
//   - Shared package arm_pipe_pkg: state enum (2-bit), INSTR_BYTES, RESET_PC default.
//   - PC register inline (async active-low reset); no separate register module.
//   - One sub-module: flush_counter (3-bit down counter: load on redirect, done flag).
// TESTING
//   1. Reset=0 then release -> pc_q=0, BOOT one cycle, then imem_req_o=1 at pc_q=0.
//   2. Ack held 1 for 4 cycles -> pc_q 0,4,8,C,10; fetch_cnt_o=4; instr_valid_o each cycle.
//   3. br_taken_i with target 64'h1000 while ack=1 -> no increment, pc_q=1000, flush_ifid_o 2 cycles, no valid.
//   4. stall_i=1 for 3 cycles with ack=1 -> pc_q held at 8, imem_req_o=0; fetch resumes at 8.
//   5. Target 64'h1002 -> pc_q=1000, align_fault_o=1 sticky; PC FFFF_FFFF_FFFF_FFFC + ack -> pc_q=0.
//   6. Reset asserted mid-FLUSH -> all outputs 0 immediately (async); pc_q=RESET_PC.

Source files
------------

// File: rtl/arm_pipe_pkg.sv
// Shared IF-stage definitions: sequencer states, fetch defaults and PC helpers.
package arm_pipe_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_STALL = 2'd2,
    ST_FLUSH = 2'd3
  } pc_state_e;

  localparam logic [63:0] RESET_PC_DEFAULT    = 64'h0;
  localparam int unsigned INSTR_BYTES_DEFAULT = 4;
  localparam int unsigned FLUSH_CNT_W         = 3;

  // Redirect targets are forced onto an instruction word boundary.
  function automatic logic [63:0] word_align(input logic [63:0] addr);
    return {addr[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/flush_counter.sv
// Down counter timing the IF/ID flush window after a redirect.
// Reloaded on every redirect; o_done marks the last flush cycle.
module flush_counter
  import arm_pipe_pkg::*;
#(
  parameter int unsigned CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  output logic o_done
);

  logic [FLUSH_CNT_W-1:0] r_count;

  // Load on redirect, otherwise count down to zero and rest there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= FLUSH_CNT_W'(CYCLES);
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == FLUSH_CNT_W'(1));

endmodule

// File: rtl/pc_sequencer.sv
// IF-stage program counter sequencer: owns the 64-bit fetch PC, runs the
// imem req/ack handshake, and handles stalls, redirects and IF/ID flushes.
module pc_sequencer
  import arm_pipe_pkg::*;
#(
  parameter logic [63:0] RESET_PC     = RESET_PC_DEFAULT,
  parameter int unsigned INSTR_BYTES  = INSTR_BYTES_DEFAULT,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        stall_i,
  input  logic        br_taken_i,
  input  logic [63:0] br_target_i,
  output logic        imem_req_o,
  input  logic        imem_ack_i,
  output logic [63:0] pc_q,
  output logic        instr_valid_o,
  output logic        flush_ifid_o,
  output logic        align_fault_o,
  output logic [31:0] fetch_cnt_o
);

  pc_state_e   r_state;
  logic        r_req;
  logic [63:0] r_pc;
  logic [31:0] r_fetch_cnt;
  logic        r_fault;
  logic        w_accept;
  logic        w_flush_done;

  // A fetch counts only if nothing of higher priority claims the cycle.
  assign w_accept = r_req & imem_ack_i & ~stall_i & ~br_taken_i;

  flush_counter #(
    .CYCLES (FLUSH_CYCLES)
  ) u_flush_counter (
    .clk    (clk),
    .rst_n  (Reset),
    .i_load (br_taken_i),
    .o_done (w_flush_done)
  );

  // Sequencer FSM; the request line is registered alongside the state.
  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_BOOT;
      r_req   <= 1'b0;
    end else if (br_taken_i) begin
      r_state <= ST_FLUSH;
      r_req   <= 1'b1;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state <= ST_FETCH;
          r_req   <= 1'b1;
        end
        ST_FETCH: begin
          if (stall_i) begin
            r_state <= ST_STALL;
            r_req   <= 1'b0;
          end
        end
        ST_STALL: begin
          if (!stall_i) begin
            r_state <= ST_FETCH;
            r_req   <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (w_flush_done) begin
            r_state <= stall_i ? ST_STALL : ST_FETCH;
            r_req   <= ~stall_i;
          end
        end
        default: begin
          r_state <= ST_BOOT;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  // PC, saturating fetch counter and sticky alignment fault.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_pc        <= RESET_PC;
      r_fetch_cnt <= '0;
      r_fault     <= 1'b0;
    end else begin
      if (br_taken_i) begin
        r_pc <= word_align(br_target_i);
      end else if (w_accept) begin
        r_pc <= r_pc + 64'(INSTR_BYTES);
      end
      if (w_accept && (r_fetch_cnt != '1)) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (br_taken_i && (br_target_i[1:0] != 2'b00)) begin
        r_fault <= 1'b1;
      end
    end
  end

  assign imem_req_o    = r_req;
  assign pc_q          = r_pc;
  assign flush_ifid_o  = (r_state == ST_FLUSH);
  assign instr_valid_o = w_accept & (r_state != ST_FLUSH);
  assign align_fault_o = r_fault;
  assign fetch_cnt_o   = r_fetch_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a cycle table driven through a
// scoreboard queue, then a hand-written async reset in the middle of a flush.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        Reset;
  logic        stall_i;
  logic        br_taken_i;
  logic [63:0] br_target_i;
  logic        imem_req_o;
  logic        imem_ack_i;
  logic [63:0] pc_q;
  logic        instr_valid_o;
  logic        flush_ifid_o;
  logic        align_fault_o;
  logic [31:0] fetch_cnt_o;

  pc_sequencer dut (
    .clk           (clk),
    .Reset         (Reset),
    .stall_i       (stall_i),
    .br_taken_i    (br_taken_i),
    .br_target_i   (br_target_i),
    .imem_req_o    (imem_req_o),
    .imem_ack_i    (imem_ack_i),
    .pc_q          (pc_q),
    .instr_valid_o (instr_valid_o),
    .flush_ifid_o  (flush_ifid_o),
    .align_fault_o (align_fault_o),
    .fetch_cnt_o   (fetch_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        br;
    logic [63:0] tgt;
    logic        ack;
    logic        req;
    logic [63:0] pc;
    logic        valid;
    logic        flush;
    logic        fault;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic br, input logic [63:0] tgt, input logic ack,
                     input logic req, input logic [63:0] pc, input logic v, input logic f,
                     input logic fa, input logic [31:0] cnt);
    vec_t r;
    r.stall = st; r.br = br; r.tgt = tgt; r.ack = ack;
    r.req = req; r.pc = pc; r.valid = v; r.flush = f; r.fault = fa; r.cnt = cnt;
    vecs.push_back(r);
  endtask

  // Drive one cycle's inputs just after the edge, compare mid-cycle.
  task automatic run_vec(input vec_t v, input int idx);
    vec_t e;
    stall_i     = v.stall;
    br_taken_i  = v.br;
    br_target_i = v.tgt;
    imem_ack_i  = v.ack;
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    check($sformatf("row%0d req", idx),   64'(imem_req_o),    64'(e.req));
    check($sformatf("row%0d pc", idx),    pc_q,               e.pc);
    check($sformatf("row%0d valid", idx), 64'(instr_valid_o), 64'(e.valid));
    check($sformatf("row%0d flush", idx), 64'(flush_ifid_o),  64'(e.flush));
    check($sformatf("row%0d fault", idx), 64'(align_fault_o), 64'(e.fault));
    check($sformatf("row%0d cnt", idx),   64'(fetch_cnt_o),   64'(e.cnt));
    check($sformatf("row%0d excl", idx),  64'(instr_valid_o & flush_ifid_o), 64'(0));
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] TOP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  initial begin
    Reset       = 1'b0;
    stall_i     = 1'b0;
    br_taken_i  = 1'b0;
    br_target_i = 64'h0;
    imem_ack_i  = 1'b0;

    //  st br tgt        ack  req pc        v  f  fa cnt
    add(0, 0, 64'h0,     0,   0, 64'h0,     0, 0, 0, 0);  // BOOT cycle
    add(0, 0, 64'h0,     0,   1, 64'h0,     0, 0, 0, 0);  // request waits for ack
    add(0, 0, 64'h0,     1,   1, 64'h0,     1, 0, 0, 0);
    add(0, 0, 64'h0,     1,   1, 64'h4,     1, 0, 0, 1);
    add(0, 0, 64'h0,     1,   1, 64'h8,     1, 0, 0, 2);
    add(0, 0, 64'h0,     1,   1, 64'hC,     1, 0, 0, 3);
    add(0, 0, 64'h0,     0,   1, 64'h10,    0, 0, 0, 4);
    add(0, 1, 64'h1000,  1,   1, 64'h10,    0, 0, 0, 4);  // redirect beats ack
    add(0, 0, 64'h0,     0,   1, 64'h1000,  0, 1, 0, 4);
    add(0, 0, 64'h0,     0,   1, 64'h1000,  0, 1, 0, 4);
    add(1, 0, 64'h0,     1,   1, 64'h1000,  0, 0, 0, 4);  // stall discards ack
    add(1, 0, 64'h0,     1,   0, 64'h1000,  0, 0, 0, 4);
    add(1, 0, 64'h0,     1,   0, 64'h1000,  0, 0, 0, 4);
    add(0, 0, 64'h0,     1,   0, 64'h1000,  0, 0, 0, 4);
    add(0, 0, 64'h0,     1,   1, 64'h1000,  1, 0, 0, 4);  // same PC re-fetched
    add(0, 0, 64'h0,     0,   1, 64'h1004,  0, 0, 0, 5);
    add(0, 1, 64'h1002,  0,   1, 64'h1004,  0, 0, 0, 5);  // misaligned target
    add(0, 0, 64'h0,     1,   1, 64'h1000,  0, 1, 1, 5);  // fetch in flush: no valid
    add(0, 0, 64'h0,     0,   1, 64'h1004,  0, 1, 1, 6);
    add(0, 0, 64'h0,     0,   1, 64'h1004,  0, 0, 1, 6);
    add(0, 1, 64'h2000,  0,   1, 64'h1004,  0, 0, 1, 6);
    add(0, 1, 64'h3000,  0,   1, 64'h2000,  0, 1, 1, 6);  // redirect restarts flush
    add(0, 0, 64'h0,     0,   1, 64'h3000,  0, 1, 1, 6);
    add(1, 0, 64'h0,     0,   1, 64'h3000,  0, 1, 1, 6);  // flush ends into stall
    add(0, 0, 64'h0,     0,   0, 64'h3000,  0, 0, 1, 6);
    add(0, 0, 64'h0,     0,   1, 64'h3000,  0, 0, 1, 6);
    add(0, 1, TOP_PC,    0,   1, 64'h3000,  0, 0, 1, 6);
    add(0, 0, 64'h0,     0,   1, TOP_PC,    0, 1, 1, 6);
    add(0, 0, 64'h0,     0,   1, TOP_PC,    0, 1, 1, 6);
    add(0, 0, 64'h0,     1,   1, TOP_PC,    1, 0, 1, 6);
    add(0, 0, 64'h0,     0,   1, 64'h0,     0, 0, 1, 7);  // PC wrapped

    // Values held during reset.
    #12;
    check("rst pc",    pc_q,               64'h0);
    check("rst req",   64'(imem_req_o),    64'(0));
    check("rst valid", 64'(instr_valid_o), 64'(0));
    check("rst flush", 64'(flush_ifid_o),  64'(0));
    check("rst fault", 64'(align_fault_o), 64'(0));
    check("rst cnt",   64'(fetch_cnt_o),   64'(0));

    @(posedge clk);
    #1;
    Reset = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], i);
    end

    // Async reset in the middle of a flush.
    stall_i     = 1'b0;
    imem_ack_i  = 1'b0;
    br_taken_i  = 1'b1;
    br_target_i = 64'h40;
    @(posedge clk);
    #1;
    br_taken_i = 1'b0;
    check("pre flush", 64'(flush_ifid_o), 64'(1));
    check("pre pc",    pc_q,              64'h40);
    #2;
    Reset = 1'b0;
    #1;
    check("async pc",    pc_q,               64'h0);
    check("async req",   64'(imem_req_o),    64'(0));
    check("async flush", 64'(flush_ifid_o),  64'(0));
    check("async valid", 64'(instr_valid_o), 64'(0));
    check("async fault", 64'(align_fault_o), 64'(0));
    check("async cnt",   64'(fetch_cnt_o),   64'(0));
    @(posedge clk);
    #1;
    Reset = 1'b1;
    @(negedge clk);
    check("reboot req", 64'(imem_req_o), 64'(0));
    @(posedge clk);
    #1;
    check("refetch req", 64'(imem_req_o), 64'(1));
    check("refetch pc",  pc_q,            64'h0);

    check("sb drained", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
